// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run controller: FSM states, the
// registered status bundle and the tohost result encoding.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    typedef struct packed {
        logic core_reset;
        logic running;
        logic done;
        logic pass;
        logic timeout;
    } status_t;

    // Default monitored word address for test result writes.
    localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_1000;

    // Result encoding: exactly 1 means pass; any other odd value means fail
    // with the test number in the upper bits; even values are not results.
    localparam int PASS_VAL = 1;

    function automatic logic is_fail(input logic lsb, input logic is_pass);
        return lsb && !is_pass;
    endfunction

    // Status flags as seen while sitting in state s.
    function automatic status_t decode(input state_t s);
        status_t st;
        st.core_reset = (s != ST_RUN);
        st.running    = (s == ST_RUN);
        st.done       = (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
        st.pass       = (s == ST_PASS);
        st.timeout    = (s == ST_TIMEOUT);
        return st;
    endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// Core-side bus: data-memory write port and retire strobe from the core,
// reset back to the core.
interface run_ctrl_if #(
    parameter int XLEN = 32
);
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            retire;
    logic            core_reset;

    modport master (output mem_we, mem_addr, mem_wdata, retire, input core_reset);
    modport slave  (input mem_we, mem_addr, mem_wdata, retire, output core_reset);
endinterface

// File: rtl/run_ctrl_sat_counter.sv
// W-bit up counter with synchronous clear and enable; sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    // Clear wins over count; hold once saturated.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 q <= '0;
        else if (clr)               q <= '0;
        else if (en && (q != '1))   q <= q + W'(1);
    end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: holds the core in reset, lets it run, watches the tohost
// word for a pass/fail result and times out after a cycle budget.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              RESET_CYCLES = 4,
    parameter int              MAX_CYCLES   = 1000,
    parameter int              CNT_W        = 32,
    parameter logic [XLEN-1:0] TOHOST_ADDR  = XLEN'(TOHOST_ADDR_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    run_ctrl_if.slave        core,
    output logic             running,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [XLEN-2:0]  fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    state_t  state, nxt;
    status_t stat;
    logic [HW-1:0] hold_cnt;

    logic tohost, res_pass, res_fail, expire, cnt_clr;
    logic [1:0]            cnt_en;
    logic [1:0][CNT_W-1:0] cnt_q;

    assign tohost   = core.mem_we && (core.mem_addr == TOHOST_ADDR);
    assign res_pass = tohost && (core.mem_wdata == XLEN'(PASS_VAL));
    assign res_fail = tohost && is_fail(core.mem_wdata[0], res_pass);
    // Wide compare so a narrow saturating counter never aliases the budget.
    assign expire   = (64'(cnt_q[0]) == 64'(MAX_CYCLES - 1));
    assign cnt_clr  = start && stat.done;
    assign cnt_en   = {(state == ST_RUN) && core.retire, (state == ST_RUN)};

    // [0] counts run cycles, [1] counts retired instructions.
    genvar i;
    for (i = 0; i < 2; i++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (cnt_clr),
            .en    (cnt_en[i]),
            .q     (cnt_q[i])
        );
    end

    // Next state: a tohost result outranks the timeout in the same cycle.
    always_comb begin
        nxt = state;
        case (state)
            ST_HOLD: if (hold_cnt == HW'(RESET_CYCLES - 1)) nxt = ST_RUN;
            ST_RUN: begin
                if (res_pass)      nxt = ST_PASS;
                else if (res_fail) nxt = ST_FAIL;
                else if (expire)   nxt = ST_TIMEOUT;
            end
            default: if (start) nxt = ST_HOLD;
        endcase
    end

    // State, hold counter, fail code and registered status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_HOLD;
            stat      <= decode(ST_HOLD);
            hold_cnt  <= '0;
            fail_code <= '0;
        end else begin
            state <= nxt;
            stat  <= decode(nxt);
            if (state != ST_HOLD)      hold_cnt <= '0;
            else                       hold_cnt <= hold_cnt + HW'(1);
            if ((state == ST_RUN) && res_fail) fail_code <= core.mem_wdata[XLEN-1:1];
            else if (cnt_clr)                  fail_code <= '0;
        end
    end

    assign core.core_reset = stat.core_reset;
    assign running         = stat.running;
    assign done            = stat.done;
    assign pass            = stat.pass;
    assign timeout         = stat.timeout;
    assign cycle_count     = cnt_q[0];
    assign instret_count   = cnt_q[1];

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed sequences, a result-write table and a
// randomized run against a behavioural model of the controller.
module tb_run_ctrl;
    import run_ctrl_pkg::*;

    localparam logic [31:0] TH = 32'h0000_1000;
    localparam int RC = 4;
    localparam int MC = 20;
    localparam longint unsigned SAT = 64'hFFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, start_b;
    logic running, done, pass, timeout;
    logic [30:0] fail_code;
    logic [31:0] cycle_count, instret_count;
    logic b_running, b_done, b_pass, b_timeout;
    logic [30:0] b_fc;
    logic [3:0]  b_cyc, b_ins;

    run_ctrl_if #(.XLEN(32)) bus ();
    run_ctrl_if #(.XLEN(32)) bus_b ();

    run_ctrl #(.RESET_CYCLES(RC), .MAX_CYCLES(MC)) dut (
        .clk(clk), .reset(reset), .start(start), .core(bus),
        .running(running), .done(done), .pass(pass), .timeout(timeout),
        .fail_code(fail_code), .cycle_count(cycle_count), .instret_count(instret_count)
    );

    // Narrow counters, large budget: exercises saturation.
    run_ctrl #(.CNT_W(4), .MAX_CYCLES(100)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .core(bus_b),
        .running(b_running), .done(b_done), .pass(b_pass), .timeout(b_timeout),
        .fail_code(b_fc), .cycle_count(b_cyc), .instret_count(b_ins)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Behavioural model: phase plus counters, advanced once per edge.
    localparam int PH_HOLD = 0, PH_RUN = 1, PH_PASS = 2, PH_FAIL = 3, PH_TO = 4;
    int m_ph, m_hold;
    longint unsigned m_cyc, m_ins;
    logic [30:0] m_fc;

    task automatic m_reset();
        m_ph = PH_HOLD; m_hold = 0; m_cyc = 0; m_ins = 0; m_fc = '0;
    endtask

    task automatic m_step(input bit we, input logic [31:0] a, input logic [31:0] d,
                          input bit ret, input bit st);
        bit wr, last;
        wr   = we && (a == TH);
        last = (m_cyc == longint'(MC - 1));
        case (m_ph)
            PH_HOLD: begin
                m_hold++;
                if (m_hold >= RC) m_ph = PH_RUN;
            end
            PH_RUN: begin
                if (m_cyc < SAT) m_cyc++;
                if (ret && m_ins < SAT) m_ins++;
                if (wr && d == 32'd1) m_ph = PH_PASS;
                else if (wr && (d % 2 == 1)) begin m_ph = PH_FAIL; m_fc = d[31:1]; end
                else if (last) m_ph = PH_TO;
            end
            default: if (st) m_reset();
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".core_reset"}, bus.core_reset, m_ph != PH_RUN);
        chk({tag, ".running"},    running,        m_ph == PH_RUN);
        chk({tag, ".done"},       done,           m_ph >= PH_PASS);
        chk({tag, ".pass"},       pass,           m_ph == PH_PASS);
        chk({tag, ".timeout"},    timeout,        m_ph == PH_TO);
        chk({tag, ".fail_code"},  fail_code,      m_fc);
        chk({tag, ".cycles"},     cycle_count,    m_cyc);
        chk({tag, ".instret"},    instret_count,  m_ins);
    endtask

    task automatic cyc(input bit we, input logic [31:0] a, input logic [31:0] d,
                       input bit ret, input bit st, input string tag);
        bus.mem_we = we; bus.mem_addr = a; bus.mem_wdata = d; bus.retire = ret; start = st;
        m_step(we, a, d, ret, st);
        @(posedge clk); #1;
        check_all(tag);
    endtask

    task automatic idle(input int n, input bit ret, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, ret, 1'b0, tag);
    endtask

    // Reset pulse between edges; outputs must change with no clock edge.
    task automatic async_rst(input string tag);
        #1 reset = 1'b0;
        #1 m_reset();
        check_all(tag);
        #1 reset = 1'b1;
    endtask

    task automatic to_run(input string tag);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, tag);
        idle(RC, 1'b0, tag);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          e_run;
        bit          e_pass;
        bit          e_done;
        logic [30:0] e_fc;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{TH,            32'h7,         1'b0, 1'b0, 1'b1, 31'h3};
        tbl[1] = '{32'h0000_1004, 32'h7,         1'b1, 1'b0, 1'b0, 31'h0};
        tbl[2] = '{TH,            32'h4,         1'b1, 1'b0, 1'b0, 31'h0};
        tbl[3] = '{TH,            32'h1,         1'b0, 1'b1, 1'b1, 31'h0};
        tbl[4] = '{TH,            32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 31'h7FFF_FFFF};
        tbl[5] = '{TH,            32'h0,         1'b1, 1'b0, 1'b0, 31'h0};

        start = 1'b0; start_b = 1'b0;
        bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.retire = 1'b0;
        bus_b.mem_we = 1'b0; bus_b.mem_addr = '0; bus_b.mem_wdata = '0; bus_b.retire = 1'b1;
        reset = 1'b1;
        #1 reset = 1'b0;
        m_reset();
        #1 check_all("rst");
        @(posedge clk); #1 check_all("rst_hold");
        #2 reset = 1'b1;

        // Hold length after release.
        idle(RC - 1, 1'b0, "hold");
        chk("hold3.core_reset", bus.core_reset, 1'b1);
        idle(1, 1'b0, "hold");
        chk("hold4.core_reset", bus.core_reset, 1'b0);
        chk("hold4.running", running, 1'b1);

        // Budget runs out with no write; narrow counters saturate meanwhile.
        idle(30, 1'b0, "to");
        chk("to.timeout", timeout, 1'b1);
        chk("to.cycles", cycle_count, 32'd20);
        chk("sat.cycles", b_cyc, 4'hF);
        chk("sat.instret", b_ins, 4'hF);
        chk("sat.running", b_running, 1'b1);
        chk("sat.timeout", b_timeout, 1'b0);
        chk("sat.done", b_done | b_pass, 1'b0);
        chk("sat.fc", b_fc, 31'h0);

        // Pass at run cycle 10, retiring every cycle.
        to_run("restart");
        idle(10, 1'b1, "run10");
        cyc(1'b1, TH, 32'h1, 1'b1, 1'b0, "pass_wr");
        chk("p10.pass", pass, 1'b1);
        chk("p10.done", done, 1'b1);
        chk("p10.cycles", cycle_count, 32'd11);
        chk("p10.instret", instret_count, 32'd11);
        idle(3, 1'b1, "frozen");
        chk("p10.frozen", cycle_count, 32'd11);

        // Start in PASS clears and re-holds; start in RUN is ignored.
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "st_pass");
        chk("st.cycles", cycle_count, 32'd0);
        chk("st.core_reset", bus.core_reset, 1'b1);
        idle(RC - 1, 1'b0, "st_hold");
        chk("st_hold.core_reset", bus.core_reset, 1'b1);
        idle(1, 1'b0, "st_run");
        chk("st_run.running", running, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "st_in_run");
        chk("st_in_run.running", running, 1'b1);

        // Pass written on the same cycle the budget expires.
        idle(18, 1'b0, "near_to");
        cyc(1'b1, TH, 32'h1, 1'b0, 1'b0, "race");
        chk("race.pass", pass, 1'b1);
        chk("race.timeout", timeout, 1'b0);
        chk("race.cycles", cycle_count, 32'd20);

        // Asynchronous reset in the middle of a run.
        to_run("pre_rst");
        idle(5, 1'b1, "pre_rst");
        async_rst("midrun");
        chk("midrun.running", running, 1'b0);
        chk("midrun.cycles", cycle_count, 32'd0);
        idle(RC, 1'b0, "post_rst");
        chk("post_rst.running", running, 1'b1);

        // Result-write table.
        foreach (tbl[k]) begin
            async_rst("tbl_rst");
            idle(RC + 3, 1'b1, "tbl_pre");
            cyc(1'b1, tbl[k].addr, tbl[k].wdata, 1'b1, 1'b0, "tbl_wr");
            chk($sformatf("tbl%0d.running", k), running, tbl[k].e_run);
            chk($sformatf("tbl%0d.pass", k), pass, tbl[k].e_pass);
            chk($sformatf("tbl%0d.done", k), done, tbl[k].e_done);
            chk($sformatf("tbl%0d.fail_code", k), fail_code, tbl[k].e_fc);
            cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "tbl_start");
            chk($sformatf("tbl%0d.fc_clr", k), fail_code, 31'h0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            bit we, ret, st;
            logic [31:0] a, d;
            we  = ($urandom_range(0, 3) == 0);
            ret = $urandom_range(0, 1) == 1;
            st  = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0, 1:    a = TH;
                2:       a = TH + 32'd4;
                default: a = $urandom;
            endcase
            d = ($urandom_range(0, 4) == 0) ? 32'($urandom) : 32'($urandom_range(0, 9));
            cyc(we, a, d, ret, st, "rand");
            if ($urandom_range(0, 149) == 0) async_rst("rand_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 The parameter XLEN SHALL default to 32 and set the data-bus width.
REQ-002 The parameter RESET_CYCLES SHALL default to 4 and set the core reset hold length in cycles; legal values are 1 or more.
REQ-003 The parameter MAX_CYCLES SHALL default to 1000 and set the run-cycle budget before timeout; legal values are 1 or more.
REQ-004 The parameter CNT_W SHALL default to 32 and set the width of both counters.
REQ-005 The parameter TOHOST_ADDR SHALL default to 32'h0000_1000 and set the word address monitored for test result writes.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low block reset.
REQ-008 start  input  1  single-cycle request to re-run the core from a DONE state.
REQ-009 mem_we  input  1  core data-memory write strobe.
REQ-010 mem_addr  input  XLEN  core data-memory write address.
REQ-011 mem_wdata  input  XLEN  core data-memory write data.
REQ-012 retire  input  1  one instruction retired this cycle.
REQ-013 core_reset  output  1  active-high reset driven to the core.
REQ-014 running  output  1  high while in RUN.
REQ-015 done  output  1  high in any terminal state.
REQ-016 pass  output  1  high only in PASS.
REQ-017 timeout  output  1  high only in TIMEOUT.
REQ-018 fail_code  output  XLEN-1  test number reported on failure.
REQ-019 cycle_count  output  CNT_W  cycles spent in RUN.
REQ-020 instret_count  output  CNT_W  instructions retired in RUN.

Function
REQ-021 The FSM SHALL have exactly five states: HOLD, RUN, PASS, FAIL, TIMEOUT.
REQ-022 In HOLD, core_reset SHALL be 1 and a hold counter SHALL count rising edges; the FSM SHALL enter RUN on the edge where RESET_CYCLES edges have elapsed since entering HOLD.
REQ-023 In RUN, core_reset SHALL be 0, cycle_count SHALL increment by 1 every cycle, and instret_count SHALL increment by 1 on each cycle with retire=1.
REQ-024 A tohost write is a cycle in RUN with mem_we=1 and mem_addr==TOHOST_ADDR; writes to any other address SHALL be ignored.
REQ-025 A tohost write with mem_wdata==1 SHALL move the FSM to PASS on the next edge.
REQ-026 A tohost write with mem_wdata odd and not equal to 1 SHALL move the FSM to FAIL and latch fail_code = mem_wdata[XLEN-1:1].
REQ-027 A tohost write with even mem_wdata SHALL be ignored.
REQ-028 When cycle_count reaches MAX_CYCLES-1 and increments in RUN with no tohost result that cycle, the FSM SHALL enter TIMEOUT.
REQ-029 If a tohost result and the timeout coincide in the same cycle, the tohost result SHALL take priority.
REQ-030 In PASS, FAIL and TIMEOUT, core_reset SHALL be 1 and both counters SHALL freeze.
REQ-031 start=1 in a terminal state SHALL clear both counters and fail_code and enter HOLD.
REQ-032 start SHALL be ignored in HOLD and RUN.
REQ-033 Both counters SHALL saturate at all-ones and never wrap.
REQ-034 All outputs SHALL be registered or decoded from state only, with no combinational path from any input to any output.

Reset
REQ-035 While reset=0, the FSM SHALL be in HOLD, core_reset=1, the hold counter, both counters and fail_code SHALL be 0, and running, done, pass and timeout SHALL be 0.
REQ-036 Assertion of reset at any time, including mid-RUN, SHALL take effect immediately and asynchronously.
REQ-037 After reset is released, the RESET_CYCLES hold count SHALL restart from 0.

Structure
REQ-038 The package run_ctrl_pkg SHALL hold the state enum and the default TOHOST_ADDR and result encodings: PASS_VAL = 1, and "odd means fail".
REQ-039 The block SHALL instantiate one sub-module, sat_counter, which is a CNT_W-bit saturating counter with clear and enable, used twice.

Verification
REQ-040 Reset release with RESET_CYCLES=4 -> core_reset falls after exactly 4 edges, and running rises on the same edge.
REQ-041 Tohost write of 0x1 at run cycle 10 with retire every cycle -> pass=1, done=1, cycle_count=11 and instret_count=11, both frozen.
REQ-042 Tohost write of 0x7 -> FAIL with fail_code=3, pass=0; a write of 0x7 to 0x1004 instead -> still RUN.
REQ-043 MAX_CYCLES=20 with no write -> timeout=1 and cycle_count=20; a write of 0x1 on cycle 19 -> PASS, not TIMEOUT.
REQ-044 start pulse in PASS -> counters cleared, core_reset=1 for 4 cycles, then RUN; a start pulse during RUN -> no effect.
REQ-045 Reset asserted mid-RUN -> all outputs reach their reset values with no clock edge, then a full HOLD sequence follows release.
